// File: rtl/dbg_hex_entry_pkg.sv
// rtl/dbg_hex_entry_pkg.sv - shared constants and helpers for the front-panel hex entry block
//
// Contents:
//   BTN_WRITE / BTN_MOVE / BTN_COMMIT  index of each pushbutton within btn_n[2:0]
//   NUM_BTNS                           number of pushbuttons
//   DEBOUNCE_CYCLES_DEFAULT            10 ms of stable level at 50 MHz
//   nibble_msb()                       cursor index -> msb bit position of that nibble

package dbg_hex_entry_pkg;

    localparam int BTN_WRITE  = 0;
    localparam int BTN_MOVE   = 1;
    localparam int BTN_COMMIT = 2;
    localparam int NUM_BTNS   = 3;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Nibble 0 is the most significant nibble of the word (bits 63:60), so the
    // display reads left-to-right in the same order the operator keys it.
    function automatic logic [5:0] nibble_msb(input logic [3:0] idx);
        return 6'd63 - {idx, 2'b00};
    endfunction

endpackage

// File: rtl/dbg_hex_entry_debounce.sv
// rtl/dbg_hex_entry_debounce.sv - synchroniser, debounce counter and press pulse for one button
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   btn_n  in   raw active-low button, asynchronous to clk
//   press  out  single-cycle pulse when the debounced level goes released -> pressed
//
// A clean falling edge on btn_n produces press DEBOUNCE_CYCLES+2 cycles later:
// two cycles through the synchroniser, then DEBOUNCE_CYCLES cycles of agreement
// before the stable level flips (the flip and the pulse happen on the same edge).

module dbg_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q,  sync1_d;
    logic          sync2_q,  sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          press_q,  press_d;

    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;

        if (sync2_q == stable_q) begin
            // Level agrees with the accepted one (or a bounce returned to it):
            // any partial count is discarded.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            // Only the released -> pressed transition is reported.
            press_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dbg_hex_entry.sv
// rtl/dbg_hex_entry.sv - front-panel 64-bit hex word entry with valid/ready commit output
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   btn_n[2:0] in   raw active-low buttons: [0]=WRITE [1]=MOVE [2]=COMMIT
//   sw[9:0]    in   [3:0]=nibble value, [8]=MOVE clears buffer, [9]=MOVE goes back
//   disp_data  out  edit buffer, to the 7-segment debug display
//   disp_page  out  cursor[3:2], the 16-bit group holding the cursor
//   cursor     out  nibble being edited, 0 = bits 63:60, 15 = bits 3:0
//   out_valid  out  committed word pending for the core
//   out_ready  in   core accepts out_data when out_valid & out_ready at posedge
//   out_data   out  committed word, stable while out_valid is high
//   overrun    out  sticky: a COMMIT arrived while the previous word was still pending

module dbg_hex_entry
    import dbg_hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  btn_n,
    input  logic [9:0]  sw,
    output logic [63:0] disp_data,
    output logic [1:0]  disp_page,
    output logic [3:0]  cursor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        overrun
);

    logic [NUM_BTNS-1:0] press;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        dbg_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n[i]),
            .press (press[i])
        );
    end

    logic [63:0] buf_q,       buf_d;
    logic [3:0]  cursor_q,    cursor_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q,  out_data_d;
    logic        overrun_q,   overrun_d;
    logic        accept;

    // sw[7:4] are not part of this function.
    logic unused_sw;
    assign unused_sw = &{1'b0, sw[7:4]};

    assign accept = out_valid_q & out_ready;

    always_comb begin
        buf_d       = buf_q;
        cursor_d    = cursor_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;

        // Edit path: WRITE has priority, a simultaneous MOVE is discarded.
        if (press[BTN_WRITE]) begin
            buf_d[nibble_msb(cursor_q) -: 4] = sw[3:0];
            cursor_d = cursor_q + 4'd1;
        end else if (press[BTN_MOVE]) begin
            if (sw[8]) begin
                buf_d    = '0;
                cursor_d = 4'd0;
            end else if (sw[9]) begin
                cursor_d = cursor_q - 4'd1;
            end else begin
                cursor_d = cursor_q + 4'd1;
            end
        end

        // Commit path reads buf_q, i.e. the word as it stood before any
        // same-cycle edit. A slot freed by acceptance on this edge can be
        // refilled on the same edge, so back-to-back commits see no bubble.
        if (press[BTN_COMMIT]) begin
            if (!out_valid_q || accept) begin
                out_data_d  = buf_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            cursor_q    <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cursor_q    <= cursor_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign disp_data = buf_q;
    assign disp_page = cursor_q[3:2];
    assign cursor    = cursor_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dbg_hex_entry.sv
// tb/tb_dbg_hex_entry.sv - self-checking bench for dbg_hex_entry

module tb_dbg_hex_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  btn_n;
    logic [9:0]  sw;
    logic [63:0] disp_data;
    logic [1:0]  disp_page;
    logic [3:0]  cursor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        overrun;

    always #5 clk = ~clk;

    dbg_hex_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .sw        (sw),
        .disp_data (disp_data),
        .disp_page (disp_page),
        .cursor    (cursor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overrun   (overrun)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change #1 after posedge; a handshake seen at negedge completes on the next posedge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] mask);
        btn_n = btn_n & ~mask;
        tick(10);
        btn_n = btn_n | mask;
        tick(10);
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got %h expected no transfer", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_out_data", out_data, sb_exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_n     = 3'b111;
        sw        = '0;
        out_ready = 1'b0;

        // 1. reset
        tick(3);
        check("rst_disp", disp_data, 64'h0);
        check("rst_cursor", 64'(cursor), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        tick(10);
        check("idle_cursor", 64'(cursor), 64'd0);
        check("idle_disp", disp_data, 64'h0);

        // 2. bouncing WRITE, then held low
        sw = 10'h00A;
        for (int i = 0; i < 10; i++) begin
            btn_n[0] = ~btn_n[0];
            tick(2);
        end
        btn_n[0] = 1'b0;
        tick(10);
        btn_n[0] = 1'b1;
        tick(10);
        check("bounce_disp", disp_data, 64'hA000_0000_0000_0000);
        check("bounce_cursor", 64'(cursor), 64'd1);

        sw = 10'h200;
        press(3'b010);
        check("back_cursor", 64'(cursor), 64'd0);

        // 3. sixteen writes
        for (int i = 0; i < 16; i++) begin
            sw = 10'(i);
            press(3'b001);
            if (i == 4) begin
                check("w5_cursor", 64'(cursor), 64'd5);
                check("w5_page", 64'(disp_page), 64'd1);
            end
        end
        check("w16_disp", disp_data, 64'h0123_4567_89AB_CDEF);
        check("w16_cursor", 64'(cursor), 64'd0);
        check("w16_page", 64'(disp_page), 64'd0);

        // 4. MOVE variants
        sw = 10'h200;
        press(3'b010);
        check("mv_back_cursor", 64'(cursor), 64'd15);
        check("mv_back_page", 64'(disp_page), 64'd3);
        check("mv_back_disp", disp_data, 64'h0123_4567_89AB_CDEF);
        sw = 10'h100;
        press(3'b010);
        check("mv_clr_disp", disp_data, 64'h0);
        check("mv_clr_cursor", 64'(cursor), 64'd0);
        sw = 10'h000;
        press(3'b010);
        check("mv_fwd_cursor", 64'(cursor), 64'd1);
        sw = 10'h200;
        press(3'b010);
        check("mv_back0_cursor", 64'(cursor), 64'd0);
        sw = 10'h203;
        press(3'b011);
        check("wm_disp", disp_data, 64'h3000_0000_0000_0000);
        check("wm_cursor", 64'(cursor), 64'd1);

        // 5. commit, overrun, accept
        sw = 10'h005;
        press(3'b001);
        sw = 10'h007;
        exp_q.push_back(64'h3500_0000_0000_0000);
        press(3'b101);
        check("c1_valid", 64'(out_valid), 64'd1);
        check("c1_data", out_data, 64'h3500_0000_0000_0000);
        check("c1_disp", disp_data, 64'h3570_0000_0000_0000);
        check("c1_cursor", 64'(cursor), 64'd3);
        check("c1_overrun", 64'(overrun), 64'd0);
        press(3'b100);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_data", out_data, 64'h3500_0000_0000_0000);
        check("ovr_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("acc_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        check("idle_ready_valid", 64'(out_valid), 64'd0);

        // 6. commit on the acceptance edge
        exp_q.push_back(64'h3570_0000_0000_0000);
        press(3'b100);
        check("c2_valid", 64'(out_valid), 64'd1);
        sw = 10'h009;
        press(3'b001);
        check("c2_disp", disp_data, 64'h3579_0000_0000_0000);
        exp_q.push_back(64'h3579_0000_0000_0000);
        btn_n[2] = 1'b0;
        tick(6);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_data", out_data, 64'h3579_0000_0000_0000);
        btn_n[2] = 1'b1;
        tick(10);
        check("b2b_hold_valid", 64'(out_valid), 64'd1);
        check("overrun_sticky", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("b2b_acc_valid", 64'(out_valid), 64'd0);

        // reset in the middle of a debounce count
        sw = 10'h005;
        btn_n[0] = 1'b0;
        tick(4);
        reset = 1'b1;
        btn_n[0] = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);
        check("rstmid_disp", disp_data, 64'h0);
        check("rstmid_cursor", 64'(cursor), 64'd0);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_overrun", 64'(overrun), 64'd0);
        check("rstmid_data", out_data, 64'h0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
